// File: rtl/row_packer.sv
// Serial RGB pixel to full-row packer with a shadow row buffer, row/frame
// position tracking and start-of-frame resynchronisation.
module row_packer #(
    parameter int COL   = 256,
    parameter int ROW   = 256,
    parameter int WIDTH = 8
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [3*WIDTH-1:0]         pix_in,
    input  logic                       pix_valid,
    input  logic                       pix_sof,
    output logic                       pix_ready,
    output logic [COL*3*WIDTH-1:0]     row_out,
    output logic                       row_valid,
    output logic                       row_set,
    input  logic                       row_ack,
    output logic [$clog2(ROW)-1:0]     row_idx,
    output logic                       row_last,
    output logic                       frame_done,
    output logic                       err_sync
);

    localparam int PW = 3 * WIDTH;
    localparam int RL = COL * PW;
    localparam int CW = (COL > 1) ? $clog2(COL) : 1;
    localparam int RW = $clog2(ROW);

    logic [RL-1:0] shadow_q, shadow_d;
    logic [RL-1:0] row_out_q, row_out_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_cnt_q, row_cnt_d;
    logic [RW-1:0] row_idx_q, row_idx_d;
    logic [RW-1:0] held_idx_q, held_idx_d;
    logic          shadow_full_q, shadow_full_d;
    logic          row_valid_q, row_valid_d;
    logic          row_set_q, row_set_d;
    logic          frame_done_q, frame_done_d;
    logic          err_sync_q, err_sync_d;

    logic          accept;
    logic          slot_free;
    logic [CW-1:0] eff_col;
    logic [CW-1:0] slot;
    logic [RW-1:0] eff_row;

    assign pix_ready = !shadow_full_q;
    assign accept    = pix_valid && pix_ready;
    assign slot_free = !row_valid_q || row_ack;
    // start-of-frame forces the pixel into column 0 of row 0
    assign eff_col   = pix_sof ? '0 : col_q;
    assign eff_row   = pix_sof ? '0 : row_cnt_q;
    assign slot      = CW'(COL - 1) - eff_col;

    always_comb begin
        shadow_d      = shadow_q;
        row_out_d     = row_out_q;
        col_d         = col_q;
        row_cnt_d     = row_cnt_q;
        row_idx_d     = row_idx_q;
        held_idx_d    = held_idx_q;
        shadow_full_d = shadow_full_q;
        row_valid_d   = row_valid_q;
        row_set_d     = 1'b0;
        frame_done_d  = 1'b0;
        err_sync_d    = err_sync_q;

        if (row_ack) begin
            row_valid_d = 1'b0;
        end

        if (accept) begin
            shadow_d[slot*PW +: PW] = pix_in;
            if (pix_sof && (col_q != '0)) begin
                err_sync_d = 1'b1;
            end
            if (eff_col == CW'(COL - 1)) begin
                col_d     = '0;
                row_cnt_d = (eff_row == RW'(ROW - 1)) ? '0 : eff_row + RW'(1);
                if (slot_free) begin
                    row_out_d    = shadow_d;
                    row_valid_d  = 1'b1;
                    row_idx_d    = eff_row;
                    row_set_d    = 1'b1;
                    frame_done_d = (eff_row == RW'(ROW - 1));
                end else begin
                    shadow_full_d = 1'b1;
                    held_idx_d    = eff_row;
                end
            end else begin
                col_d     = eff_col + CW'(1);
                row_cnt_d = eff_row;
            end
        end else if (shadow_full_q && row_ack) begin
            row_out_d     = shadow_q;
            row_valid_d   = 1'b1;
            row_idx_d     = held_idx_q;
            row_set_d     = 1'b1;
            frame_done_d  = (held_idx_q == RW'(ROW - 1));
            shadow_full_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            shadow_q      <= '0;
            row_out_q     <= '0;
            col_q         <= '0;
            row_cnt_q     <= '0;
            row_idx_q     <= '0;
            held_idx_q    <= '0;
            shadow_full_q <= 1'b0;
            row_valid_q   <= 1'b0;
            row_set_q     <= 1'b0;
            frame_done_q  <= 1'b0;
            err_sync_q    <= 1'b0;
        end else begin
            shadow_q      <= shadow_d;
            row_out_q     <= row_out_d;
            col_q         <= col_d;
            row_cnt_q     <= row_cnt_d;
            row_idx_q     <= row_idx_d;
            held_idx_q    <= held_idx_d;
            shadow_full_q <= shadow_full_d;
            row_valid_q   <= row_valid_d;
            row_set_q     <= row_set_d;
            frame_done_q  <= frame_done_d;
            err_sync_q    <= err_sync_d;
        end
    end

    assign row_out    = row_out_q;
    assign row_valid  = row_valid_q;
    assign row_set    = row_set_q;
    assign row_idx    = row_idx_q;
    assign row_last   = (row_idx_q == RW'(ROW - 1));
    assign frame_done = frame_done_q;
    assign err_sync   = err_sync_q;

endmodule
